// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling and a frame error pulse.
// Latency: valid follows the start edge by about 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles.
// Backpressure: none; the consumer must capture data_out on the valid pulse.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_txd_in,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    sync;
    logic          rx;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    sh, sh_nxt;
    logic [7:0]    dout_nxt;
    logic          valid_nxt, ferr_nxt;

    assign rx   = sync[1];
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= 2'b11;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync      <= {sync[0], uart_txd_in};
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            sh        <= sh_nxt;
            data_out  <= dout_nxt;
            valid     <= valid_nxt;
            frame_err <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        sh_nxt    = sh;
        dout_nxt  = data_out;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                // Half a bit in: confirm the start bit at its centre.
                if (cnt == CW'(HALF - 1)) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = rx ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_nxt     = '0;
                    sh_nxt[idx] = rx;
                    if (idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP: begin
                // Leaving at mid stop bit lets an immediately following start bit be seen.
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_nxt = '0;
                    if (rx) begin
                        dout_nxt  = sh;
                        valid_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rx) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: good frames, glitch, frame error,
// back-to-back frames, mid-frame reset and a long break.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line = 1'b1;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int         n_run = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         t_fall = 0;
    int         vld_cnt = 0;
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    logic [7:0] vld_data [0:7];
    int         vld_cyc  [0:7];
    logic       busy_at_vld = 1'b1;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_txd_in(line),
        .data_out   (data_out),
        .valid      (valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (vld_cnt < 8) begin
                vld_data[vld_cnt] = data_out;
                vld_cyc[vld_cnt]  = cyc;
            end
            busy_at_vld = busy;
            vld_cnt++;
        end
        if (frame_err === 1'b1) ferr_cnt++;
        if (valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    task automatic clear_mon();
        @(posedge clk);
        vld_cnt     = 0;
        ferr_cnt    = 0;
        busy_at_vld = 1'b1;
        @(negedge clk);
    endtask

    task automatic bit_time(input logic v);
        line = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        t_fall = cyc;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        line = 1'b1;
        repeat (3) @(negedge clk);
        n_run++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data_out); end
        n_run++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
        n_run++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", frame_err); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        clear_mon();
        send_byte(8'h53, 1'b1);
        line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_run++; if (vld_cnt !== 1) begin n_fail++; $display("FAIL basic_count got %0d want 1", vld_cnt); end
        n_run++; if (vld_data[0] !== 8'h53) begin n_fail++; $display("FAIL basic_data got %h want 53", vld_data[0]); end
        n_run++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL basic_ferr got %0d want 0", ferr_cnt); end
        n_run++; if (busy_at_vld !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b/%b want 0/0", busy_at_vld, busy); end
        lat = vld_cyc[0] - t_fall;
        n_run++; if (lat < 154 || lat > 156) begin n_fail++; $display("FAIL basic_latency got %0d want 155+/-1", lat); end
    endtask

    task automatic test_glitch();
        clear_mon();
        line = 1'b0;
        repeat (5) @(negedge clk);
        line = 1'b1;
        repeat (12) @(negedge clk);
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got %b want 0", busy); end
        n_run++; if (vld_cnt !== 0) begin n_fail++; $display("FAIL glitch_valid got %0d want 0", vld_cnt); end
        n_run++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL glitch_ferr got %0d want 0", ferr_cnt); end
    endtask

    task automatic test_frame_err();
        clear_mon();
        send_byte(8'hA5, 1'b0);
        line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_run++; if (ferr_cnt !== 1) begin n_fail++; $display("FAIL ferr_count got %0d want 1", ferr_cnt); end
        n_run++; if (vld_cnt !== 0) begin n_fail++; $display("FAIL ferr_valid got %0d want 0", vld_cnt); end
        n_run++; if (data_out !== 8'h53) begin n_fail++; $display("FAIL ferr_data got %h want 53", data_out); end
    endtask

    task automatic test_back_to_back();
        int gap;
        clear_mon();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_run++; if (vld_cnt !== 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", vld_cnt); end
        n_run++; if (vld_data[0] !== 8'h00) begin n_fail++; $display("FAIL b2b_first got %h want 00", vld_data[0]); end
        n_run++; if (vld_data[1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second got %h want ff", vld_data[1]); end
        gap = vld_cyc[1] - vld_cyc[0];
        n_run++; if (gap < 159 || gap > 161) begin n_fail++; $display("FAIL b2b_spacing got %0d want 160+/-1", gap); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] b;
        b = 8'h3C;
        clear_mon();
        bit_time(1'b0);
        for (int i = 0; i < 3; i++) bit_time(b[i]);
        line = b[3];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_run++; if (busy !== 1'b0 || valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL abort_rst_outs got busy=%b valid=%b ferr=%b want 0/0/0", busy, valid, frame_err);
        end
        n_run++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL abort_rst_data got %h want 00", data_out); end
        repeat (CPB / 2 - 1) @(negedge clk);
        bit_time(b[4]);
        bit_time(b[5]);
        line = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        n_run++; if (vld_cnt !== 0 || ferr_cnt !== 0) begin
            n_fail++; $display("FAIL abort_pulses got valid=%0d ferr=%0d want 0/0", vld_cnt, ferr_cnt);
        end
        send_byte(8'hC3, 1'b1);
        line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_run++; if (vld_cnt !== 1) begin n_fail++; $display("FAIL abort_next_count got %0d want 1", vld_cnt); end
        n_run++; if (vld_data[0] !== 8'hC3) begin n_fail++; $display("FAIL abort_next_data got %h want c3", vld_data[0]); end
    endtask

    task automatic test_break();
        clear_mon();
        line = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_run++; if (ferr_cnt !== 1) begin n_fail++; $display("FAIL break_ferr got %0d want 1", ferr_cnt); end
        n_run++; if (vld_cnt !== 0) begin n_fail++; $display("FAIL break_valid got %0d want 0", vld_cnt); end
        n_run++; if (data_out !== 8'hC3) begin n_fail++; $display("FAIL break_data got %h want c3", data_out); end
        clear_mon();
        send_byte(8'h7E, 1'b1);
        line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_run++; if (vld_cnt !== 1 || vld_data[0] !== 8'h7E) begin
            n_fail++; $display("FAIL break_next got count=%0d data=%h want 1/7e", vld_cnt, vld_data[0]);
        end
        n_run++; if (both_cnt !== 0) begin n_fail++; $display("FAIL overlap got %0d want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_abort();
        test_break();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
